// File: rtl/multicycle_control.sv
//-----------------------------------------------------------------------------
// multicycle_control
//   Moore-style main control FSM for a multicycle MIPS-like datapath. The
//   state register steps through fetch, decode and the per-class execute and
//   write-back states. The datapath controls are decoded combinationally from
//   the current state. A few of them also depend on op, jr or mem_ready.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; all outputs are 0 while low
//   op[5:0]      opcode field from the instruction register
//   jr           jr_control from the ALU control block
//   mem_ready    memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   ALUOp1, ALUOp0, ALUSrcA, RegWrite, RegDst   single-bit datapath controls
//   PCSource[1:0]  00 ALU, 01 ALUOut, 10 jump target, 11 register (jr)
//   ALUSrcB[1:0]   00 reg, 01 constant 4, 10 sign-ext imm, 11 shifted imm
//   state_out[3:0] current state encoding
//   illegal_op     unsupported opcode seen in DECODE
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_SLTI  = 6'b001010,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       jr,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state_out,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic       illegal_op;
  } ctrl_t;

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_out;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and output decode
  always_comb begin
    // NOTE: every signal gets a default here first, so no path leaves one unassigned and no latch is inferred.
    w_next = S_FETCH;
    w_ctrl = '0;

    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = 2'b01;
        // The PC increment and IR load happen only when the fetch returns data.
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
        w_next           = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        w_ctrl.alu_src_b = 2'b11;
        if (op == OP_LW || op == OP_SW)         w_next = S_MEMADR;
        else if (op == OP_RTYPE)                w_next = S_EXECUTE;
        else if (op == OP_BEQ)                  w_next = S_BRANCH;
        else if (op == OP_ADDI || op == OP_SLTI) w_next = S_IMMEX;
        else if (op == OP_J)                    w_next = S_JUMP;
        else begin
          w_ctrl.illegal_op = 1'b1;
          w_next            = S_FETCH;
        end
      end

      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end

      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
        w_next          = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next            = S_FETCH;
      end

      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
        w_next           = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_EXECUTE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = 2'b10;
        // jr completes here by loading the PC from the register operand.
        if (jr) begin
          w_ctrl.pc_write  = 1'b1;
          w_ctrl.pc_source = 2'b11;
          w_next           = S_FETCH;
        end else begin
          w_next = S_ALUWB;
        end
      end

      S_ALUWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_next           = S_FETCH;
      end

      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = 2'b01;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = 2'b01;
        w_next               = S_FETCH;
      end

      S_IMMEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        w_ctrl.alu_op    = (op == OP_SLTI) ? 2'b11 : 2'b00;
        w_next           = S_IMMWB;
      end

      S_IMMWB: begin
        w_ctrl.reg_write = 1'b1;
        w_next           = S_FETCH;
      end

      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = 2'b10;
        w_next           = S_FETCH;
      end

      // Encodings 12-15 are unreachable; recover to FETCH with outputs idle.
      default: begin
        w_next = S_FETCH;
        w_ctrl = '0;
      end
    endcase
  end

  // The state register already holds FETCH during reset. The outputs are
  // gated as well, because FETCH would otherwise drive MemRead.
  assign w_ctrl_out = rst_n ? w_ctrl : '0;

  assign PCWrite     = w_ctrl_out.pc_write;
  assign PCWriteCond = w_ctrl_out.pc_write_cond;
  assign IorD        = w_ctrl_out.i_or_d;
  assign MemRead     = w_ctrl_out.mem_read;
  assign MemWrite    = w_ctrl_out.mem_write;
  assign MemtoReg    = w_ctrl_out.mem_to_reg;
  assign IRWrite     = w_ctrl_out.ir_write;
  assign ALUOp1      = w_ctrl_out.alu_op[1];
  assign ALUOp0      = w_ctrl_out.alu_op[0];
  assign ALUSrcA     = w_ctrl_out.alu_src_a;
  assign RegWrite    = w_ctrl_out.reg_write;
  assign RegDst      = w_ctrl_out.reg_dst;
  assign PCSource    = w_ctrl_out.pc_source;
  assign ALUSrcB     = w_ctrl_out.alu_src_b;
  assign illegal_op  = w_ctrl_out.illegal_op;
  assign state_out   = rst_n ? r_state : S_FETCH;

endmodule

// File: tb/tb_multicycle_control.sv
//-----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed testbench for multicycle_control. All outputs are packed into
//   one observation vector. The layout is
//   {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//    ALUOp1, ALUOp0, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
//    state_out, illegal_op}.
//   The bench compares that vector against hand-written per-state constants.
//   Inputs change on the falling edge, and outputs are sampled 1 ns later.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // Expected vectors, fields: {ctrl12, PCSource, ALUSrcB, state, illegal_op}
  // ctrl12 = PCWrite PCWriteCond IorD MemRead | MemWrite MemtoReg IRWrite ALUOp1 | ALUOp0 ALUSrcA RegWrite RegDst
  localparam logic [20:0] E_ZERO     = 21'd0;
  localparam logic [20:0] E_FETCH_R  = {12'b1001_0010_0000, 2'b00, 2'b01, 4'd0,  1'b0};
  localparam logic [20:0] E_FETCH_N  = {12'b0001_0000_0000, 2'b00, 2'b01, 4'd0,  1'b0};
  localparam logic [20:0] E_DECODE   = {12'b0000_0000_0000, 2'b00, 2'b11, 4'd1,  1'b0};
  localparam logic [20:0] E_DEC_ILL  = {12'b0000_0000_0000, 2'b00, 2'b11, 4'd1,  1'b1};
  localparam logic [20:0] E_MEMADR   = {12'b0000_0000_0100, 2'b00, 2'b10, 4'd2,  1'b0};
  localparam logic [20:0] E_MEMRD    = {12'b0011_0000_0000, 2'b00, 2'b00, 4'd3,  1'b0};
  localparam logic [20:0] E_MEMWB    = {12'b0000_0100_0010, 2'b00, 2'b00, 4'd4,  1'b0};
  localparam logic [20:0] E_MEMWR    = {12'b0010_1000_0000, 2'b00, 2'b00, 4'd5,  1'b0};
  localparam logic [20:0] E_EXEC_JR  = {12'b1000_0001_0100, 2'b11, 2'b00, 4'd6,  1'b0};
  localparam logic [20:0] E_EXEC     = {12'b0000_0001_0100, 2'b00, 2'b00, 4'd6,  1'b0};
  localparam logic [20:0] E_ALUWB    = {12'b0000_0000_0011, 2'b00, 2'b00, 4'd7,  1'b0};
  localparam logic [20:0] E_BRANCH   = {12'b0100_0000_1100, 2'b01, 2'b00, 4'd8,  1'b0};
  localparam logic [20:0] E_IMMEX_S  = {12'b0000_0001_1100, 2'b00, 2'b10, 4'd9,  1'b0};
  localparam logic [20:0] E_IMMEX_A  = {12'b0000_0000_0100, 2'b00, 2'b10, 4'd9,  1'b0};
  localparam logic [20:0] E_IMMWB    = {12'b0000_0000_0010, 2'b00, 2'b00, 4'd10, 1'b0};
  localparam logic [20:0] E_JUMP     = {12'b1000_0000_0000, 2'b10, 2'b00, 4'd11, 1'b0};

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       jr;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       ALUOp1, ALUOp0, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB;
  logic [3:0] state_out;
  logic       illegal_op;
  logic [20:0] w_obs;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .jr(jr), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .state_out(state_out), .illegal_op(illegal_op)
  );

  assign w_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  ALUOp1, ALUOp0, ALUSrcA, RegWrite, RegDst,
                  PCSource, ALUSrcB, state_out, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle: drive mem_ready on the falling edge and sample 1 ns later.
  task automatic step(input logic mr, output logic [20:0] obs);
    @(negedge clk);
    mem_ready = mr;
    #1;
    obs = w_obs;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    rst_n = 1'b0; op = OP_LW; jr = 1'b0; mem_ready = 1'b1;
    #3;
    n_checks++;
    if (w_obs !== E_ZERO) begin
      n_fail++; $display("FAIL reset_initial: got %h expected %h", w_obs, E_ZERO);
    end
    step(1'b1, obs);
    n_checks++;
    if (obs !== E_ZERO) begin
      n_fail++; $display("FAIL reset_held_over_edge: got %h expected %h", obs, E_ZERO);
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== E_FETCH_N) begin
      n_fail++; $display("FAIL reset_release_fetch: got %h expected %h", w_obs, E_FETCH_N);
    end
  endtask

  task automatic test_lw();
    logic [20:0] obs;
    logic [20:0] exp_v [0:5];
    logic        mr_v  [0:5];
    exp_v = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH_N};
    mr_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(mr_v[i], obs);
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL lw cycle %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 0) begin op = OP_LW; jr = 1'b0; end
    end
  endtask

  task automatic test_jr();
    logic [20:0] obs;
    logic [20:0] exp_v [0:2];
    exp_v = '{E_FETCH_R, E_DECODE, E_EXEC_JR};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, obs);
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL jr cycle %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 0) begin op = OP_RTYPE; jr = 1'b1; end
    end
  endtask

  task automatic test_rtype_fetch_wait();
    logic [20:0] obs;
    logic [20:0] exp_v [0:5];
    logic        mr_v  [0:5];
    exp_v = '{E_FETCH_N, E_FETCH_N, E_FETCH_R, E_DECODE, E_EXEC, E_ALUWB};
    mr_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(mr_v[i], obs);
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL rtype_wait cycle %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 0) begin op = OP_RTYPE; jr = 1'b0; end
    end
  endtask

  task automatic test_sw_wait();
    logic [20:0] obs;
    logic [20:0] exp_v [0:7];
    logic        mr_v  [0:7];
    exp_v = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR, E_FETCH_N};
    mr_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(mr_v[i], obs);
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL sw_wait cycle %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 0) begin op = OP_SW; jr = 1'b0; end
    end
  endtask

  task automatic test_imm(input logic [5:0] opc, input logic [20:0] e_immex);
    logic [20:0] obs;
    logic [20:0] exp_v [0:3];
    exp_v = '{E_FETCH_R, E_DECODE, e_immex, E_IMMWB};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, obs);
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL imm op=%b cycle %0d: got %h expected %h", opc, i, obs, exp_v[i]);
      end
      if (i == 0) begin op = opc; jr = 1'b0; end
    end
  endtask

  task automatic test_beq_j();
    logic [20:0] obs;
    logic [20:0] exp_v [0:5];
    exp_v = '{E_FETCH_R, E_DECODE, E_BRANCH, E_FETCH_R, E_DECODE, E_JUMP};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, obs);
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL beq_j cycle %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 0) op = OP_BEQ;
      if (i == 3) op = OP_J;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] obs;
    logic [20:0] exp_v [0:2];
    logic        mr_v  [0:2];
    exp_v = '{E_FETCH_R, E_DEC_ILL, E_FETCH_N};
    mr_v  = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(mr_v[i], obs);
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 0) begin op = OP_BAD; jr = 1'b0; end
    end
  endtask

  task automatic test_reset_mid_memrd();
    logic [20:0] obs;
    logic [20:0] exp_v [0:4];
    logic [20:0] exp_j [0:2];
    logic        mr_v  [0:4];
    exp_v = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD};
    mr_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(mr_v[i], obs);
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL mid_reset_lw cycle %0d: got %h expected %h", i, obs, exp_v[i]);
      end
      if (i == 0) begin op = OP_LW; jr = 1'b0; end
    end
    // Assert reset in the low phase: outputs must clear before any rising edge.
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== E_ZERO) begin
      n_fail++; $display("FAIL mid_reset_async: got %h expected %h", w_obs, E_ZERO);
    end
    step(1'b1, obs);
    n_checks++;
    if (obs !== E_ZERO) begin
      n_fail++; $display("FAIL mid_reset_held: got %h expected %h", obs, E_ZERO);
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    op = OP_J;
    exp_j = '{E_FETCH_R, E_DECODE, E_JUMP};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, obs);
      n_checks++;
      if (obs !== exp_j[i]) begin
        n_fail++; $display("FAIL resume_j cycle %0d: got %h expected %h", i, obs, exp_j[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_jr();
    test_rtype_fetch_wait();
    test_sw_wait();
    test_imm(OP_SLTI, E_IMMEX_S);
    test_imm(OP_ADDI, E_IMMEX_A);
    test_beq_j();
    test_illegal();
    test_reset_mid_memrd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
